scalar_writeback_arbiter: RTL and testbench

- Writer side of the scalar register file write port: merges ALU-pipeline results and memory-load results into one registered write per cycle (wb_writeback_reg / wb_writeback_value / wb_enable_scalar_writeback).
- The ALU path has fixed latency and cannot stall, so it always wins. Load results are queued in a small FIFO and drain in ALU bubbles.
- Sits between the execute/memory stages and scalar_register_file; throttles instruction issue when the load queue nears full.

---
 rtl/scalar_writeback_arbiter_pkg.sv | 20 ++
 rtl/scalar_writeback_arbiter_wb_fifo.sv | 81 ++++++++
 rtl/scalar_writeback_arbiter.sv | 108 ++++++++++
 tb/tb_scalar_writeback_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/scalar_writeback_arbiter_pkg.sv
// Shared types for the scalar writeback arbiter: register index width and the
// entry format used by the load queue, the write port and the optional bypass.
package scalar_writeback_arbiter_pkg;

  localparam int SWB_REG_IDX_WIDTH = 7;
  localparam int SWB_VALUE_WIDTH   = 32;

  typedef struct packed {
    logic [SWB_REG_IDX_WIDTH-1:0] idx;
    logic [SWB_VALUE_WIDTH-1:0]   value;
    logic                         live;
  } scalar_wb_t;

  // A live entry aimed at register r is made stale by a younger ALU write to r.
  function automatic logic entry_hits_reg(input scalar_wb_t e,
                                          input logic [SWB_REG_IDX_WIDTH-1:0] r);
    return e.live && (e.idx == r);
  endfunction

endpackage

// File: rtl/scalar_writeback_arbiter_wb_fifo.sv
// scalar_wb_fifo: load-result queue with per-entry live bits that a concurrent
// ALU write can clear by register index.
module scalar_wb_fifo
  import scalar_writeback_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  scalar_wb_t                   push_entry_i,
  input  logic                         pop_i,
  input  logic                         kill_valid_i,
  input  logic [SWB_REG_IDX_WIDTH-1:0] kill_reg_i,
  output scalar_wb_t                   head_o,
  output logic [CNT_W-1:0]             count_o,
  output logic [CNT_W-1:0]             count_next_o,
  output logic                         empty_o
);

  scalar_wb_t       entries_q [DEPTH];
  scalar_wb_t       entries_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] kill_vec_s;

  // Entries hit by this cycle's ALU write.
  always_comb begin
    kill_vec_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_vec_s[i] = kill_valid_i && entry_hits_reg(entries_q[i], kill_reg_i);
    end
  end

  // Next storage, pointers and count; a push lands after the kill, so a load
  // accepted alongside an ALU write to the same register stays live.
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_vec_s[i]) begin
        entries_d[i].live = 1'b0;
      end else begin
        entries_d[i].live = entries_q[i].live;
      end
    end
    if (push_i) begin
      entries_d[wr_ptr_q] = push_entry_i;
    end else begin
      entries_d[wr_ptr_q] = entries_d[wr_ptr_q];
    end
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, pop_i};
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  assign head_o       = entries_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign empty_o      = (count_q == '0);

endmodule

// File: rtl/scalar_writeback_arbiter.sv
// Scalar register-file write-port arbiter: ALU results always win, loads queue
// and drain in ALU bubbles. Optional bypass ports under SCALAR_WB_BYPASS_EN.
module scalar_writeback_arbiter
  import scalar_writeback_arbiter_pkg::*;
#(
  parameter int REG_IDX_WIDTH   = SWB_REG_IDX_WIDTH,
  parameter int LOAD_FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_result_valid,
  input  logic [REG_IDX_WIDTH-1:0] ex_result_reg,
  input  logic [31:0]              ex_result_value,
  input  logic                     mem_result_valid,
  output logic                     mem_result_ready,
  input  logic [REG_IDX_WIDTH-1:0] mem_result_reg,
  input  logic [31:0]              mem_result_value,
  output logic                     wb_suspend_issue,
  output logic [REG_IDX_WIDTH-1:0] wb_writeback_reg,
  output logic [31:0]              wb_writeback_value,
  output logic                     wb_enable_scalar_writeback
`ifdef SCALAR_WB_BYPASS_EN
  ,
  output logic                     wb_bypass_valid,
  output logic [REG_IDX_WIDTH-1:0] wb_bypass_reg,
  output logic [31:0]              wb_bypass_value
`endif
);

  localparam int CNT_W = $clog2(LOAD_FIFO_DEPTH) + 1;

  scalar_wb_t       wb_q, wb_d;
  logic             suspend_q, suspend_d;
  scalar_wb_t       ex_entry_s, mem_entry_s, head_s;
  logic [CNT_W-1:0] count_s, count_next_s;
  logic             empty_s, handshake_s, push_s, pop_s;

  assign ex_entry_s  = '{idx: SWB_REG_IDX_WIDTH'(ex_result_reg),
                         value: ex_result_value, live: 1'b1};
  assign mem_entry_s = '{idx: SWB_REG_IDX_WIDTH'(mem_result_reg),
                         value: mem_result_value, live: 1'b1};

  // Ready depends only on stored count, so it never looks at ex_result_valid.
  assign mem_result_ready = (count_s < CNT_W'(LOAD_FIFO_DEPTH));
  assign handshake_s      = mem_result_valid && mem_result_ready;

  scalar_wb_fifo #(.DEPTH(LOAD_FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_s),
    .push_entry_i (mem_entry_s),
    .pop_i        (pop_s),
    .kill_valid_i (ex_result_valid),
    .kill_reg_i   (ex_entry_s.idx),
    .head_o       (head_s),
    .count_o      (count_s),
    .count_next_o (count_next_s),
    .empty_o      (empty_s)
  );

  // Write-port selection: ALU, then queue head (dead heads pop silently), then
  // empty-queue load bypass; an idle cycle holds reg/value with enable low.
  always_comb begin
    wb_d      = '{idx: wb_q.idx, value: wb_q.value, live: 1'b0};
    push_s    = 1'b0;
    pop_s     = 1'b0;
    suspend_d = (count_next_s >= CNT_W'(LOAD_FIFO_DEPTH - 1));
    if (ex_result_valid) begin
      wb_d   = ex_entry_s;
      push_s = handshake_s;
    end else if (!empty_s) begin
      pop_s  = 1'b1;
      push_s = handshake_s;
      if (head_s.live) begin
        wb_d = head_s;
      end else begin
        wb_d.live = 1'b0;
      end
    end else if (handshake_s) begin
      wb_d = mem_entry_s;
    end else begin
      wb_d.live = 1'b0;
    end
  end

  // Registered write port and issue throttle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q      <= '0;
      suspend_q <= 1'b0;
    end else begin
      wb_q      <= wb_d;
      suspend_q <= suspend_d;
    end
  end

  assign wb_enable_scalar_writeback = wb_q.live;
  assign wb_writeback_reg           = REG_IDX_WIDTH'(wb_q.idx);
  assign wb_writeback_value         = wb_q.value;
  assign wb_suspend_issue           = suspend_q;

`ifdef SCALAR_WB_BYPASS_EN
  assign wb_bypass_valid = wb_q.live;
  assign wb_bypass_reg   = REG_IDX_WIDTH'(wb_q.idx);
  assign wb_bypass_value = wb_q.value;
`endif

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Directed scoreboard bench for scalar_writeback_arbiter (depth 4, 7-bit regs).
module tb_scalar_writeback_arbiter;

  typedef struct packed {
    logic        en;
    logic [6:0]  r;
    logic [31:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_result_valid;
  logic [6:0]  ex_result_reg;
  logic [31:0] ex_result_value;
  logic        mem_result_valid;
  logic        mem_result_ready;
  logic [6:0]  mem_result_reg;
  logic [31:0] mem_result_value;
  logic        wb_suspend_issue;
  logic [6:0]  wb_writeback_reg;
  logic [31:0] wb_writeback_value;
  logic        wb_enable_scalar_writeback;
`ifdef SCALAR_WB_BYPASS_EN
  logic        wb_bypass_valid;
  logic [6:0]  wb_bypass_reg;
  logic [31:0] wb_bypass_value;
`endif

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  logic [6:0]  last_reg;
  logic [31:0] last_val;

  scalar_writeback_arbiter dut (
    .clk                        (clk),
    .reset                      (reset),
    .ex_result_valid            (ex_result_valid),
    .ex_result_reg              (ex_result_reg),
    .ex_result_value            (ex_result_value),
    .mem_result_valid           (mem_result_valid),
    .mem_result_ready           (mem_result_ready),
    .mem_result_reg             (mem_result_reg),
    .mem_result_value           (mem_result_value),
    .wb_suspend_issue           (wb_suspend_issue),
    .wb_writeback_reg           (wb_writeback_reg),
    .wb_writeback_value         (wb_writeback_value),
    .wb_enable_scalar_writeback (wb_enable_scalar_writeback)
`ifdef SCALAR_WB_BYPASS_EN
    ,
    .wb_bypass_valid            (wb_bypass_valid),
    .wb_bypass_reg              (wb_bypass_reg),
    .wb_bypass_value            (wb_bypass_value)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue its expected write, then compare once it lands.
  task automatic step(input string tag,
                      input logic exv, input logic [6:0] exr, input logic [31:0] exd,
                      input logic mv,  input logic [6:0] mr,  input logic [31:0] md,
                      input logic een, input logic [6:0] er,  input logic [31:0] ed,
                      input logic erdy, input logic esus);
    exp_t e;
    ex_result_valid  = exv;
    ex_result_reg    = exr;
    ex_result_value  = exd;
    mem_result_valid = mv;
    mem_result_reg   = mr;
    mem_result_value = md;
    #1;
    chk({tag, ":ready"}, 32'(mem_result_ready), 32'(erdy));
    sb.push_back('{en: een, r: er, v: ed});
    @(posedge clk);
    #1;
    ex_result_valid  = 1'b0;
    mem_result_valid = 1'b0;
    e = sb.pop_front();
    if (e.en) begin
      last_reg = e.r;
      last_val = e.v;
    end
    chk({tag, ":enable"},  32'(wb_enable_scalar_writeback), 32'(e.en));
    chk({tag, ":reg"},     32'(wb_writeback_reg), 32'(last_reg));
    chk({tag, ":value"},   wb_writeback_value, last_val);
    chk({tag, ":suspend"}, 32'(wb_suspend_issue), 32'(esus));
`ifdef SCALAR_WB_BYPASS_EN
    chk({tag, ":byp_valid"}, 32'(wb_bypass_valid), 32'(e.en));
    chk({tag, ":byp_reg"},   32'(wb_bypass_reg), 32'(last_reg));
    chk({tag, ":byp_value"}, wb_bypass_value, last_val);
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ":enable"},  32'(wb_enable_scalar_writeback), 32'd0);
    chk({tag, ":reg"},     32'(wb_writeback_reg), 32'd0);
    chk({tag, ":value"},   wb_writeback_value, 32'd0);
    chk({tag, ":ready"},   32'(mem_result_ready), 32'd1);
    chk({tag, ":suspend"}, 32'(wb_suspend_issue), 32'd0);
`ifdef SCALAR_WB_BYPASS_EN
    chk({tag, ":byp_valid"}, 32'(wb_bypass_valid), 32'd0);
`endif
  endtask

  initial begin
    reset            = 1'b0;
    ex_result_valid  = 1'b0;
    ex_result_reg    = 7'd0;
    ex_result_value  = 32'd0;
    mem_result_valid = 1'b0;
    mem_result_reg   = 7'd0;
    mem_result_value = 32'd0;
    last_reg         = 7'd0;
    last_val         = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");
    reset = 1'b1;

    // ALU only, then an idle cycle that must hold reg/value.
    step("alu",  1'b1, 7'd5, 32'hDEADBEEF, 1'b0, 7'd0, 32'd0, 1'b1, 7'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    step("idle", 1'b0, 7'd0, 32'd0,        1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0,        1'b1, 1'b0);

    // Empty-queue load bypass; nothing may be left behind in the queue.
    step("byp",      1'b0, 7'd0, 32'd0, 1'b1, 7'd7, 32'h55, 1'b1, 7'd7, 32'h55, 1'b1, 1'b0);
    step("byp_idle", 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0,  1'b0, 7'd0, 32'd0,  1'b1, 1'b0);

    // Contention: loads queue behind an ALU stream, ready/suspend thresholds,
    // full-but-popping keeps ready low, push+pop in one cycle, in-order drain.
    step("ct0", 1'b1, 7'd1, 32'h101, 1'b1, 7'd10, 32'h100A, 1'b1, 7'd1, 32'h101, 1'b1, 1'b0);
    step("ct1", 1'b1, 7'd2, 32'h102, 1'b1, 7'd11, 32'h100B, 1'b1, 7'd2, 32'h102, 1'b1, 1'b0);
    step("ct2", 1'b1, 7'd3, 32'h103, 1'b1, 7'd12, 32'h100C, 1'b1, 7'd3, 32'h103, 1'b1, 1'b1);
    step("ct3", 1'b1, 7'd4, 32'h104, 1'b1, 7'd13, 32'h100D, 1'b1, 7'd4, 32'h104, 1'b1, 1'b1);
    step("ct4", 1'b1, 7'd5, 32'h105, 1'b1, 7'd14, 32'h100E, 1'b1, 7'd5, 32'h105, 1'b0, 1'b1);
    step("ct5", 1'b1, 7'd6, 32'h106, 1'b0, 7'd0,  32'd0,    1'b1, 7'd6, 32'h106, 1'b0, 1'b1);
    step("ct6", 1'b0, 7'd0, 32'd0,   1'b1, 7'd14, 32'h100E, 1'b1, 7'd10, 32'h100A, 1'b0, 1'b1);
    step("ct7", 1'b0, 7'd0, 32'd0,   1'b1, 7'd15, 32'h100F, 1'b1, 7'd11, 32'h100B, 1'b1, 1'b1);
    step("ct8", 1'b0, 7'd0, 32'd0,   1'b0, 7'd0,  32'd0,    1'b1, 7'd12, 32'h100C, 1'b1, 1'b0);
    step("ct9", 1'b0, 7'd0, 32'd0,   1'b0, 7'd0,  32'd0,    1'b1, 7'd13, 32'h100D, 1'b1, 1'b0);
    step("ctA", 1'b0, 7'd0, 32'd0,   1'b0, 7'd0,  32'd0,    1'b1, 7'd15, 32'h100F, 1'b1, 1'b0);
    step("ctB", 1'b0, 7'd0, 32'd0,   1'b0, 7'd0,  32'd0,    1'b0, 7'd0,  32'd0,    1'b1, 1'b0);

    // Kill: queued load to r20 is superseded by a younger ALU write to r20.
    step("kl0", 1'b1, 7'd9,  32'h9, 1'b1, 7'd20, 32'h1, 1'b1, 7'd9,  32'h9, 1'b1, 1'b0);
    step("kl1", 1'b1, 7'd20, 32'h2, 1'b0, 7'd0,  32'd0, 1'b1, 7'd20, 32'h2, 1'b1, 1'b0);
    step("kl2", 1'b0, 7'd0,  32'd0, 1'b0, 7'd0,  32'd0, 1'b0, 7'd0,  32'd0, 1'b1, 1'b0);
    step("kl3", 1'b0, 7'd0,  32'd0, 1'b0, 7'd0,  32'd0, 1'b0, 7'd0,  32'd0, 1'b1, 1'b0);

    // Load accepted with an ALU write to the same register is younger: kept live.
    step("sr0", 1'b1, 7'd21, 32'hA, 1'b1, 7'd21, 32'hB, 1'b1, 7'd21, 32'hA, 1'b1, 1'b0);
    step("sr1", 1'b0, 7'd0,  32'd0, 1'b0, 7'd0,  32'd0, 1'b1, 7'd21, 32'hB, 1'b1, 1'b0);

    // Reset mid-queue: three loads waiting, reset discards them.
    step("rq0", 1'b1, 7'd1, 32'h201, 1'b1, 7'd30, 32'h300, 1'b1, 7'd1, 32'h201, 1'b1, 1'b0);
    step("rq1", 1'b1, 7'd2, 32'h202, 1'b1, 7'd31, 32'h301, 1'b1, 7'd2, 32'h202, 1'b1, 1'b0);
    step("rq2", 1'b1, 7'd3, 32'h203, 1'b1, 7'd32, 32'h302, 1'b1, 7'd3, 32'h203, 1'b1, 1'b1);
    reset = 1'b0;
    #2;
    chk_reset_state("mid_rst");
    @(posedge clk);
    #1;
    reset    = 1'b1;
    last_reg = 7'd0;
    last_val = 32'd0;
    for (int i = 0; i < 5; i++) begin
      step("post_rst", 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0);
    end

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
